uart_rx_oversampler: RTL and testbench

Serial-to-parallel UART receiver. Consumes the 16x-baud sampling tick from the baud generator stage and the asynchronous `rx` line, then recovers one character per frame using 3-sample majority voting. Delivers each character on a valid/ready interface with per-character parity and framing status. Sits directly downstream of the baud generator and upstream of the receive FIFO / register file.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx_oversampler.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_oversampler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: receiver FSM states, oversampling geometry and config decode.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    // Tick-counter values bracketing the middle of a bit, and the last tick of a bit.
    localparam int SMP_A   = 7;
    localparam int SMP_B   = 8;
    localparam int SMP_C   = 9;
    localparam int BIT_END = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // cfg_data_bits 0..3 selects 5..8 data bits.
    function automatic logic [3:0] data_bits(input logic [1:0] cfg);
        return 4'd5 + {2'b00, cfg};
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an idle-high asynchronous input; both stages reset to 1.
// Latency: 2 clk.
// Backpressure: none, free-running.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_oversampler.sv
// UART receiver: 16x oversampling, 3-sample majority vote, parity/framing check, one-entry output slot.
// Latency: rx_valid rises one clk after the mid-point tick of the last stop bit.
// Backpressure: a frame completing into a full slot without rx_ready is dropped and pulses rx_overrun.
module uart_rx_oversampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic              rx,
    input  logic [1:0]        cfg_data_bits,
    input  logic              cfg_parity_en,
    input  logic              cfg_parity_odd,
    input  logic              cfg_stop2,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_parity_err,
    output logic              rx_frame_err,
    output logic              rx_overrun,
    output logic              rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [TW-1:0] T_A   = TW'(SMP_A);
    localparam logic [TW-1:0] T_B   = TW'(SMP_B);
    localparam logic [TW-1:0] T_C   = TW'(SMP_C);
    localparam logic [TW-1:0] T_END = TW'(BIT_END);

    rx_state_t         state, state_nxt;
    logic [TW-1:0]     tcnt, tcnt_nxt;
    logic              rxs;
    logic              smp_a, smp_b, maj;
    logic              start_det, frame_done;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic [3:0]        nbits;
    logic              stop_idx;
    logic              par_pend, frm_pend;
    logic [1:0]        cfg_bits_q;
    logic              cfg_par_en_q, cfg_par_odd_q, cfg_stop2_q;
    logic              at_mid, at_end;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    assign nbits   = data_bits(cfg_bits_q);
    assign maj     = (smp_a & smp_b) | (smp_a & rxs) | (smp_b & rxs);
    assign at_mid  = sample_tick && (tcnt == T_C);
    assign at_end  = sample_tick && (tcnt == T_END);
    assign rx_busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tcnt_nxt   = tcnt;
        start_det  = 1'b0;
        frame_done = 1'b0;
        if (sample_tick) begin
            tcnt_nxt = tcnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    tcnt_nxt = '0;
                    if (!rxs) begin
                        state_nxt = ST_START;
                        tcnt_nxt  = TW'(1);
                        start_det = 1'b1;
                    end
                end
                ST_START: begin
                    if (tcnt == T_C && maj) begin
                        state_nxt = ST_IDLE;
                        tcnt_nxt  = '0;
                    end else if (tcnt == T_END) begin
                        state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tcnt == T_END && bit_cnt == BW'(nbits))
                        state_nxt = cfg_par_en_q ? ST_PARITY : ST_STOP;
                end
                ST_PARITY: begin
                    if (tcnt == T_END)
                        state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    // Complete mid-way through the last stop bit so the next start edge is not missed.
                    if (tcnt == T_C && (stop_idx || !cfg_stop2_q)) begin
                        state_nxt  = ST_IDLE;
                        tcnt_nxt   = '0;
                        frame_done = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    tcnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_a         <= 1'b1;
            smp_b         <= 1'b1;
            shreg         <= '0;
            bit_cnt       <= '0;
            stop_idx      <= 1'b0;
            par_pend      <= 1'b0;
            frm_pend      <= 1'b0;
            cfg_bits_q    <= '0;
            cfg_par_en_q  <= 1'b0;
            cfg_par_odd_q <= 1'b0;
            cfg_stop2_q   <= 1'b0;
        end else begin
            if (sample_tick && tcnt == T_A)
                smp_a <= rxs;
            if (sample_tick && tcnt == T_B)
                smp_b <= rxs;
            if (start_det) begin
                cfg_bits_q    <= cfg_data_bits;
                cfg_par_en_q  <= cfg_parity_en;
                cfg_par_odd_q <= cfg_parity_odd;
                cfg_stop2_q   <= cfg_stop2;
                shreg         <= '0;
                bit_cnt       <= '0;
                stop_idx      <= 1'b0;
                par_pend      <= 1'b0;
                frm_pend      <= 1'b0;
            end
            if (at_mid && state == ST_DATA) begin
                shreg   <= shreg | (DATA_W'(maj) << bit_cnt);
                bit_cnt <= bit_cnt + 1'b1;
            end
            // Unused MSBs of shreg stay zero, so a full-width XOR is the data parity.
            if (at_mid && state == ST_PARITY && maj != (^shreg ^ cfg_par_odd_q))
                par_pend <= 1'b1;
            if (at_mid && state == ST_STOP && !maj)
                frm_pend <= 1'b1;
            if (at_end && state == ST_STOP)
                stop_idx <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (frame_done && (!rx_valid || rx_ready)) begin
                rx_data       <= shreg;
                rx_parity_err <= par_pend;
                rx_frame_err  <= frm_pend | ~maj;
                rx_valid      <= 1'b1;
            end else begin
                if (frame_done)
                    rx_overrun <= 1'b1;
                if (rx_valid && rx_ready)
                    rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed and randomized frames against a bit-level frame builder and expected-character model.
module tb_uart_rx_oversampler;

    logic       clk;
    logic       rst;
    logic       sample_tick;
    logic       rx;
    logic [1:0] cfg_data_bits;
    logic       cfg_parity_en;
    logic       cfg_parity_odd;
    logic       cfg_stop2;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int valid_rises = 0;
    int ovr_cnt = 0;
    logic v_before, v_after;

    uart_rx_oversampler #(.OVERSAMPLE(16), .DATA_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_tick    (sample_tick),
        .rx             (rx),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_parity_err  (rx_parity_err),
        .rx_frame_err   (rx_frame_err),
        .rx_overrun     (rx_overrun),
        .rx_busy        (rx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One tick every 4 clk, driven on the falling edge ahead of the posedge that sees it.
    initial begin
        int ph;
        ph = 0;
        sample_tick = 1'b0;
        forever begin
            @(negedge clk);
            sample_tick = (ph == 0);
            ph = (ph + 1) % 4;
        end
    end

    initial begin
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid && !prev_v)
                valid_rises++;
            if (rx_overrun)
                ovr_cnt++;
            prev_v = rx_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Leaves us just after the falling edge whose following posedge carries a tick.
    task automatic align_tick();
        do begin
            @(negedge clk);
            #1;
        end while (!sample_tick);
    endtask

    // 64 clk per bit. bad_stop selects which stop bit (0/1) is driven low, -1 for none.
    task automatic send_frame(input logic [7:0] data, input int nbits, input bit par_en,
                              input bit odd, input bit stop2, input bit bad_par,
                              input int bad_stop, input bit ready_at_done);
        logic [11:0] bits;
        logic [7:0]  mask;
        int          nb;
        cfg_data_bits  = 2'(nbits - 5);
        cfg_parity_en  = par_en;
        cfg_parity_odd = odd;
        cfg_stop2      = stop2;
        mask = 8'((1 << nbits) - 1);
        bits = '0;
        for (int i = 0; i < nbits; i++)
            bits[1 + i] = data[i];
        nb = 1 + nbits;
        if (par_en) begin
            bits[nb] = (^(data & mask)) ^ odd ^ bad_par;
            nb++;
        end
        for (int s = 0; s < (stop2 ? 2 : 1); s++) begin
            bits[nb] = (bad_stop == s) ? 1'b0 : 1'b1;
            nb++;
        end
        align_tick();
        for (int b = 0; b < nb; b++) begin
            rx = bits[b];
            if (b == nb - 1) begin
                repeat (40) @(negedge clk);
                #1;
                v_before = rx_valid;
                rx_ready = ready_at_done;
                @(negedge clk);
                #1;
                v_after  = rx_valid;
                rx_ready = 1'b0;
                repeat (23) @(negedge clk);
                #1;
            end else begin
                repeat (64) @(negedge clk);
                #1;
            end
        end
        rx = 1'b1;
        repeat (64) @(negedge clk);
        #1;
    endtask

    task automatic consume(input string tag);
        rx_ready = 1'b1;
        @(negedge clk);
        #1;
        rx_ready = 1'b0;
        check(tag, 32'(rx_valid), 32'd0);
    endtask

    initial begin
        int         ovr0, rises0;
        logic [7:0] d;
        int         nbits, bad_stop;
        bit         pe, po, s2, bp;

        rst = 1'b1;
        rx = 1'b1;
        rx_ready = 1'b0;
        cfg_data_bits = 2'd3;
        cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_stop2 = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("rst_data",   32'(rx_data), 32'd0);
        check("rst_valid",  32'(rx_valid), 32'd0);
        check("rst_perr",   32'(rx_parity_err), 32'd0);
        check("rst_ferr",   32'(rx_frame_err), 32'd0);
        check("rst_ovr",    32'(rx_overrun), 32'd0);
        check("rst_busy",   32'(rx_busy), 32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        #1;

        // 0x55 8N1
        send_frame(8'h55, 8, 0, 0, 0, 0, -1, 0);
        check("t1_valid_before", 32'(v_before), 32'd0);
        check("t1_valid_after",  32'(v_after), 32'd1);
        check("t1_data",  32'(rx_data), 32'h55);
        check("t1_perr",  32'(rx_parity_err), 32'd0);
        check("t1_ferr",  32'(rx_frame_err), 32'd0);
        check("t1_busy",  32'(rx_busy), 32'd0);
        consume("t1_consume");

        // 0xA3 8E1 with the parity bit inverted from the correct value
        send_frame(8'hA3, 8, 1, 0, 0, 1, -1, 0);
        check("t2_data", 32'(rx_data), 32'hA3);
        check("t2_perr", 32'(rx_parity_err), 32'd1);
        check("t2_ferr", 32'(rx_frame_err), 32'd0);
        consume("t2_consume");

        // False start: low for 4 ticks only
        rises0 = valid_rises;
        align_tick();
        rx = 1'b0;
        repeat (16) @(negedge clk);
        #1;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("t3_busy_start", 32'(rx_busy), 32'd1);
        repeat (20) @(negedge clk);
        #1;
        check("t3_busy_pre_mid", 32'(rx_busy), 32'd1);
        @(negedge clk);
        #1;
        check("t3_busy_fall", 32'(rx_busy), 32'd0);
        repeat (100) @(negedge clk);
        #1;
        check("t3_no_valid", 32'(valid_rises), 32'(rises0));

        // 0x3C with stop bit low, then a clean 0x01
        send_frame(8'h3C, 8, 0, 0, 0, 0, 0, 0);
        check("t4_data", 32'(rx_data), 32'h3C);
        check("t4_ferr", 32'(rx_frame_err), 32'd1);
        check("t4_perr", 32'(rx_parity_err), 32'd0);
        consume("t4_consume");
        send_frame(8'h01, 8, 0, 0, 0, 0, -1, 0);
        check("t4b_data", 32'(rx_data), 32'h01);
        check("t4b_ferr", 32'(rx_frame_err), 32'd0);
        consume("t4b_consume");

        // Overrun: second frame dropped while the slot is held
        ovr0 = ovr_cnt;
        send_frame(8'h11, 8, 0, 0, 0, 0, -1, 0);
        send_frame(8'h22, 8, 0, 0, 0, 0, -1, 0);
        check("t5_data_kept", 32'(rx_data), 32'h11);
        check("t5_valid", 32'(rx_valid), 32'd1);
        check("t5_ovr_once", 32'(ovr_cnt), 32'(ovr0 + 1));
        consume("t5_consume");
        // Accept in the completion cycle: replacement without a gap or overrun
        send_frame(8'h11, 8, 0, 0, 0, 0, -1, 0);
        rises0 = valid_rises;
        send_frame(8'h22, 8, 0, 0, 0, 0, -1, 1);
        check("t5b_valid_before", 32'(v_before), 32'd1);
        check("t5b_valid_after",  32'(v_after), 32'd1);
        check("t5b_data", 32'(rx_data), 32'h22);
        check("t5b_no_ovr", 32'(ovr_cnt), 32'(ovr0 + 1));
        check("t5b_no_gap", 32'(valid_rises), 32'(rises0));
        consume("t5b_consume");

        // 5-bit 0x1F, odd parity, two stop bits
        send_frame(8'h1F, 5, 1, 1, 1, 0, -1, 0);
        check("t6_data", 32'(rx_data), 32'h1F);
        check("t6_perr", 32'(rx_parity_err), 32'd0);
        check("t6_ferr", 32'(rx_frame_err), 32'd0);
        consume("t6_consume");

        // Randomized frames
        for (int n = 0; n < 12; n++) begin
            d        = 8'($urandom);
            nbits    = $urandom_range(5, 8);
            pe       = 1'($urandom);
            po       = 1'($urandom);
            s2       = 1'($urandom);
            bp       = pe && ($urandom_range(0, 3) == 0);
            bad_stop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, s2 ? 1 : 0) : -1;
            ovr0     = ovr_cnt;
            send_frame(d, nbits, pe, po, s2, bp, bad_stop, 0);
            check("rnd_valid", 32'(rx_valid), 32'd1);
            check("rnd_data",  32'(rx_data), 32'(d & 8'((1 << nbits) - 1)));
            check("rnd_perr",  32'(rx_parity_err), 32'(bp));
            check("rnd_ferr",  32'(rx_frame_err), 32'(bad_stop >= 0));
            check("rnd_no_ovr", 32'(ovr_cnt), 32'(ovr0));
            consume("rnd_consume");
        end

        // Asynchronous reset mid-frame with a character held
        send_frame(8'h5A, 8, 0, 0, 0, 0, -1, 0);
        check("t7_held", 32'(rx_valid), 32'd1);
        align_tick();
        rx = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        check("t7_busy", 32'(rx_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t7_data",  32'(rx_data), 32'd0);
        check("t7_valid", 32'(rx_valid), 32'd0);
        check("t7_perr",  32'(rx_parity_err), 32'd0);
        check("t7_ferr",  32'(rx_frame_err), 32'd0);
        check("t7_ovr",   32'(rx_overrun), 32'd0);
        check("t7_busy0", 32'(rx_busy), 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send_frame(8'hC7, 8, 0, 0, 0, 0, -1, 0);
        check("t7_after_data", 32'(rx_data), 32'hC7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
